// File: rtl/write_back_buffer.sv
// Line write-back buffer: coalesces evictions, serves refill hits, drains FIFO-order to memory when idle.
// Write/hit complete one cycle after acceptance; up_ready drops while full or while a refill miss is in flight.
module write_back_buffer #(
  parameter int LINE_SIZE = 16,
  parameter int DEPTH     = 4,
  parameter int LADDR_W   = 28
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   up_valid,
  input  logic [LADDR_W-1:0]     up_addr,
  input  logic                   up_read,
  input  logic                   up_write,
  input  logic [LINE_SIZE*8-1:0] up_din,
  output logic                   up_ready,
  output logic                   up_out_valid,
  output logic [LINE_SIZE*8-1:0] up_dout,
  output logic                   mem_input_valid,
  output logic [LADDR_W-1:0]     mem_addr,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [LINE_SIZE*8-1:0] mem_din,
  input  logic                   mem_ready,
  input  logic                   mem_out_valid,
  input  logic [LINE_SIZE*8-1:0] mem_dout,
  output logic                   empty,
  output logic                   full
);
  localparam int DW = LINE_SIZE * 8;
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT} state_t;
  state_t state, state_nxt;

  logic [DEPTH-1:0]   ent_vld;
  logic [LADDR_W-1:0] ent_addr [DEPTH];
  logic [DW-1:0]      ent_data [DEPTH];
  logic [PW-1:0]      head, tail, hit_idx;
  logic [PW:0]        count;
  logic [LADDR_W-1:0] rd_addr;
  logic               hit, accept, wr_acc, rd_acc, drain, rd_issue;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && ent_addr[i] == up_addr) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (rd_acc && !hit) state_nxt = RD_ISSUE;
      RD_ISSUE: if (mem_ready)      state_nxt = RD_WAIT;
      RD_WAIT:  if (mem_out_valid)  state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // A drain is held off for one cycle after any request pulse so memory never sees back-to-back requests.
  always_comb begin
    empty    = (count == '0);
    full     = (count == (PW+1)'(DEPTH));
    up_ready = (state == IDLE) && !full;
    accept   = up_valid && up_ready;
    wr_acc   = accept && up_write;
    rd_acc   = accept && up_read;
    drain    = (state == IDLE) && !accept && !empty && mem_ready && !mem_input_valid;
    rd_issue = (state == RD_ISSUE) && mem_ready;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      if (hit) begin
        ent_data[hit_idx] <= up_din;
      end else begin
        ent_addr[tail] <= up_addr;
        ent_data[tail] <= up_din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ent_vld         <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      rd_addr         <= '0;
      up_out_valid    <= 1'b0;
      up_dout         <= '0;
      mem_input_valid <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_addr        <= '0;
      mem_din         <= '0;
    end else begin
      up_out_valid    <= 1'b0;
      mem_input_valid <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_addr        <= '0;
      mem_din         <= '0;
      if (wr_acc) begin
        up_out_valid <= 1'b1;
        if (!hit) begin
          ent_vld[tail] <= 1'b1;
          tail          <= tail + 1'b1;
          count         <= count + 1'b1;
        end
      end
      if (rd_acc) begin
        if (hit) begin
          up_dout      <= ent_data[hit_idx];
          up_out_valid <= 1'b1;
        end else begin
          rd_addr <= up_addr;
        end
      end
      if (drain) begin
        mem_input_valid <= 1'b1;
        mem_write       <= 1'b1;
        mem_addr        <= ent_addr[head];
        mem_din         <= ent_data[head];
        ent_vld[head]   <= 1'b0;
        head            <= head + 1'b1;
        count           <= count - 1'b1;
      end
      if (rd_issue) begin
        mem_input_valid <= 1'b1;
        mem_read        <= 1'b1;
        mem_addr        <= rd_addr;
      end
      if (state == RD_WAIT && mem_out_valid) begin
        up_dout      <= mem_dout;
        up_out_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_write_back_buffer.sv
// Randomized and directed bench for write_back_buffer against a queue-based reference model.
module tb_write_back_buffer;
  localparam int LS = 16;
  localparam int DEPTH = 4;
  localparam int AW = 28;
  localparam int DW = LS * 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          up_valid = 1'b0, up_read = 1'b0, up_write = 1'b0;
  logic [AW-1:0] up_addr = '0;
  logic [DW-1:0] up_din = '0;
  logic          up_ready, up_out_valid;
  logic [DW-1:0] up_dout;
  logic          mem_input_valid, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_ready = 1'b0, mem_out_valid = 1'b0;
  logic [DW-1:0] mem_dout = '0;
  logic          empty, full;

  write_back_buffer #(.LINE_SIZE(LS), .DEPTH(DEPTH), .LADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .up_valid(up_valid), .up_addr(up_addr), .up_read(up_read), .up_write(up_write), .up_din(up_din),
    .up_ready(up_ready), .up_out_valid(up_out_valid), .up_dout(up_dout),
    .mem_input_valid(mem_input_valid), .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_din(mem_din), .mem_ready(mem_ready), .mem_out_valid(mem_out_valid), .mem_dout(mem_dout),
    .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: buffered lines are a plain FIFO of (addr,data); mode 0 idle, 1 miss awaiting issue, 2 awaiting data.
  logic [AW-1:0] qa[$];
  logic [DW-1:0] qd[$];
  int            mode = 0;
  logic [AW-1:0] m_rd;
  logic          e_uov = 0, e_miv = 0, e_mr = 0, e_mw = 0, prev_miv;
  logic [DW-1:0] e_udout = '0, e_mdin = '0;
  logic [AW-1:0] e_maddr = '0;
  int            m_old, m_idx;
  bit            m_acc;

  always @(posedge clk) begin
    if (!reset) begin
      qa.delete(); qd.delete();
      mode = 0; e_uov = 0; e_udout = '0; e_miv = 0; e_mr = 0; e_mw = 0; e_maddr = '0; e_mdin = '0;
    end else begin
      m_old = mode;
      m_acc = up_valid && (m_old == 0) && (qa.size() < DEPTH);
      prev_miv = e_miv;
      e_uov = 0; e_miv = 0; e_mr = 0; e_mw = 0; e_maddr = '0; e_mdin = '0;
      m_idx = -1;
      for (int i = 0; i < qa.size(); i++) if (qa[i] == up_addr) m_idx = i;
      if (m_acc && up_write) begin
        if (m_idx >= 0) qd[m_idx] = up_din;
        else begin qa.push_back(up_addr); qd.push_back(up_din); end
        e_uov = 1;
      end else if (m_acc && up_read) begin
        if (m_idx >= 0) begin e_udout = qd[m_idx]; e_uov = 1; end
        else begin mode = 1; m_rd = up_addr; end
      end else if (m_old == 0 && qa.size() > 0 && mem_ready && !prev_miv) begin
        e_miv = 1; e_mw = 1; e_maddr = qa.pop_front(); e_mdin = qd.pop_front();
      end else if (m_old == 1 && mem_ready) begin
        e_miv = 1; e_mr = 1; e_maddr = m_rd; mode = 2;
      end else if (m_old == 2 && mem_out_valid) begin
        e_udout = mem_dout; e_uov = 1; mode = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("up_ready", up_ready, (mode == 0) && (qa.size() < DEPTH));
      chk("empty", empty, qa.size() == 0);
      chk("full", full, qa.size() == DEPTH);
      chk("up_out_valid", up_out_valid, e_uov);
      chk("up_dout", up_dout, e_udout);
      chk("mem_input_valid", mem_input_valid, e_miv);
      chk("mem_read", mem_read, e_mr);
      chk("mem_write", mem_write, e_mw);
      chk("mem_addr", mem_addr, e_maddr);
      chk("mem_din", mem_din, e_mdin);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit v, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    up_valid = v; up_read = v && rd; up_write = v && !rd; up_addr = a; up_din = d;
  endtask

  localparam logic [DW-1:0] DA = {4{32'hAAAA_0001}};
  localparam logic [DW-1:0] DB = {4{32'hBBBB_0002}};
  localparam logic [DW-1:0] DC = {4{32'hCCCC_0003}};
  localparam logic [DW-1:0] DD = {4{32'hDDDD_0004}};

  int pend;

  initial begin
    tick; started = 1'b1;
    tick;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_up_ready", up_ready, 1); chk("rst_empty", empty, 1); chk("rst_full", full, 0);
    chk("rst_uov", up_out_valid, 0); chk("rst_dout", up_dout, 0); chk("rst_miv", mem_input_valid, 0);

    // Single write, then drain once memory is ready.
    tick; req(1, 0, 28'h10, DA);
    tick; req(0, 0, 0, 0); mem_ready = 1;
    @(negedge clk); chk("t1_uov", up_out_valid, 1); chk("t1_empty", empty, 0);
    tick;
    @(negedge clk); chk("t1_miv", mem_input_valid, 1); chk("t1_mw", mem_write, 1);
    chk("t1_addr", mem_addr, 28'h10); chk("t1_din", mem_din, DA); chk("t1_empty_after", empty, 1);

    // Coalesce then read hit.
    tick; mem_ready = 0; req(1, 0, 28'h10, DA);
    tick; req(1, 0, 28'h10, DB);
    tick; req(1, 1, 28'h10, 0);
    tick; req(0, 0, 0, 0); mem_ready = 1;
    @(negedge clk); chk("t2_uov", up_out_valid, 1); chk("t2_dout", up_dout, DB); chk("t2_no_mem", mem_input_valid, 0);
    tick;
    @(negedge clk); chk("t2_drain_addr", mem_addr, 28'h10); chk("t2_drain_din", mem_din, DB); chk("t2_empty", empty, 1);

    // Fill to full, then drain in order.
    tick; mem_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      req(1, 0, 28'h30 + AW'(i), {4{32'h3000_0000 + i}});
      tick;
    end
    req(0, 0, 0, 0);
    @(negedge clk); chk("t3_full", full, 1); chk("t3_up_ready", up_ready, 0);
    tick; mem_ready = 1;
    tick;
    @(negedge clk); chk("t3_first_addr", mem_addr, 28'h30); chk("t3_ready_back", up_ready, 1); chk("t3_not_full", full, 0);
    repeat (7) tick;
    @(negedge clk); chk("t3_empty", empty, 1);

    // Read miss with a line queued: no drain while the miss is outstanding.
    tick; mem_ready = 0; req(1, 0, 28'h40, DD);
    tick; req(1, 1, 28'h20, 0); mem_ready = 1;
    tick; req(0, 0, 0, 0);
    tick;
    @(negedge clk); chk("t4_miv", mem_input_valid, 1); chk("t4_mr", mem_read, 1);
    chk("t4_addr", mem_addr, 28'h20); chk("t4_up_ready", up_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      @(negedge clk); chk("t4_no_drain", mem_input_valid, 0); chk("t4_no_uov", up_out_valid, 0);
    end
    tick; mem_out_valid = 1; mem_dout = DC;
    tick; mem_out_valid = 0; mem_dout = '0;
    @(negedge clk); chk("t4_uov", up_out_valid, 1); chk("t4_dout", up_dout, DC); chk("t4_miv_low", mem_input_valid, 0);
    tick;
    @(negedge clk); chk("t4_drain_addr", mem_addr, 28'h40); chk("t4_drain_din", mem_din, DD);

    // Pointer wrap: 2*DEPTH+1 write/drain pairs.
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      tick; mem_ready = 0; req(1, 0, 28'h50 + AW'(i), {4{32'h5000_0000 + i}});
      tick; req(0, 0, 0, 0); mem_ready = 1;
      tick;
      @(negedge clk); chk("t5_wrap_addr", mem_addr, 28'h50 + AW'(i)); chk("t5_wrap_din", mem_din, {4{32'h5000_0000 + i}});
    end

    // Randomized phase with a responsive memory; final cycles stop requests so everything settles.
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      if (c < 2950 && ($urandom % 3) != 0)
        req(1, $urandom % 2, AW'($urandom % 6), {$urandom, $urandom, $urandom, $urandom});
      else
        req(0, 0, 0, 0);
      mem_ready = ($urandom % 4) != 0;
      mem_out_valid = 0; mem_dout = '0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin mem_out_valid = 1; mem_dout = {$urandom, $urandom, $urandom, $urandom}; end
      end
      if (mem_input_valid && mem_read) pend = $urandom_range(1, 5);
    end
    tick; req(0, 0, 0, 0); mem_out_valid = 0; mem_ready = 1;
    repeat (10) tick;
    @(negedge clk); chk("rand_settle_empty", empty, 1);

    // Reset while waiting on memory data; a late response must be ignored.
    tick; req(1, 1, 28'h60, 0);
    tick; req(0, 0, 0, 0);
    tick; reset = 0;
    tick; reset = 1;
    @(negedge clk); chk("t6_uov", up_out_valid, 0); chk("t6_miv", mem_input_valid, 0);
    chk("t6_dout", up_dout, 0); chk("t6_empty", empty, 1); chk("t6_up_ready", up_ready, 1);
    tick; mem_out_valid = 1; mem_dout = DC;
    tick; mem_out_valid = 0; mem_dout = '0;
    @(negedge clk); chk("t6_late_ignored", up_out_valid, 0);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/write_back_buffer.md
# write_back_buffer

Line-granular write-back buffer between the L1 data cache's memory port and the block data memory. It absorbs dirty-line evictions from the cache, coalesces repeated writes to the same line, and forwards buffered lines to cache refill reads. Queued lines drain to memory in FIFO order whenever the cache is not using the port. Both sides use the cache/memory handshake: input_valid + ready on request, one-cycle output_valid on read data.

## Interface
- LINE_SIZE, 16: line size in bytes; data width is LINE_SIZE*8.
- DEPTH, 4: buffer entries; power of two, at least 2.
- LADDR_W, 28: line-address width (byte address >> log2(LINE_SIZE)).

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clk.
- up_valid  in  1  cache request valid.
- up_addr  in  LADDR_W  request line address.
- up_read  in  1  refill read request.
- up_write  in  1  eviction write request; exactly one of up_read/up_write is set when up_valid=1.
- up_din  in  LINE_SIZE*8  eviction line data.
- up_ready  out  1  request is accepted this cycle if up_valid=1.
- up_out_valid  out  1  one-cycle completion pulse, for both reads and writes.
- up_dout  out  LINE_SIZE*8  read line data; valid while up_out_valid=1.
- mem_input_valid  out  1  memory request, one-cycle pulse.
- mem_addr  out  LADDR_W  memory line address.
- mem_read  out  1  memory read.
- mem_write  out  1  memory write.
- mem_din  out  LINE_SIZE*8  memory write data.
- mem_ready  in  1  memory can accept a request.
- mem_out_valid  in  1  memory read data valid.
- mem_dout  in  LINE_SIZE*8  memory read data.
- empty  out  1  no valid entries.
- full  out  1  DEPTH valid entries.

## Operation
- Storage:
  - DEPTH entries, each holding valid, line address and data.
  - Circular FIFO with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits wide.
- FSM states:
  - IDLE
  - RD_ISSUE
  - RD_WAIT
- up_ready = (state==IDLE) && !full.
- Accepted write (IDLE, up_valid, up_ready, up_write):
  - If a valid entry has the same address, overwrite its data in place; count unchanged.
  - Otherwise write the entry at tail, then tail+1 and count+1.
  - up_out_valid pulses the next cycle.
- Accepted read, address matches a valid entry: up_dout = that entry's data, registered, and up_out_valid pulses the next cycle. No memory access. Coalescing guarantees at most one match.
- Accepted read, no match:
  - Latch the address and go to RD_ISSUE.
  - RD_ISSUE: wait for mem_ready=1, then pulse mem_input_valid with mem_read=1 and mem_addr = latched address, and go to RD_WAIT.
  - RD_WAIT: when mem_out_valid=1, register mem_dout into up_dout, pulse up_out_valid the next cycle, and return to IDLE.
- Drain:
  - Issued in IDLE only when no request is accepted that cycle, !empty and mem_ready=1.
  - Pulse mem_input_valid with mem_write=1, mem_addr/mem_din = head entry.
  - Clear the head entry's valid bit, then head+1 and count-1.
  - Entries drain strictly in FIFO order.
- Priority: an accepted upstream request beats a drain in the same cycle, so a drain never races an enqueue or a coalesce.
- When the buffer is full, up_ready=0 and drains proceed until a slot frees.
- mem_read, mem_write, mem_addr and mem_din are 0 whenever mem_input_valid=0.

## Timing
- Reset (reset=0 at an edge):
  - state=IDLE; head=tail=count=0; all entry valid bits cleared.
  - up_out_valid=0, up_dout=0, mem_input_valid=0.
  - empty=1, full=0, up_ready=1 from the first cycle after reset.
- Reset mid-operation: any outstanding memory read is abandoned, and a later mem_out_valid in IDLE is ignored. Queued lines are discarded.
- Write or read-hit latency: accepted at edge T, up_out_valid high for exactly the cycle after T.
- Read-miss latency: one cycle to reach RD_ISSUE, plus the wait for mem_ready, one issue cycle, the memory latency, and one register cycle.
- up_ready=0 in RD_ISSUE and RD_WAIT; no drain is issued in those states.
- Only one memory request is outstanding at a time; mem_input_valid is never high on two consecutive cycles.
- Pointer wrap: tail DEPTH-1 -> 0 and head DEPTH-1 -> 0 with count tracking correctly.

## Test plan
- Write address 0x10 with data A while mem_ready=0 -> up_out_valid next cycle, empty=0. Raise mem_ready -> one write pulse with addr 0x10 and data A, then empty=1.
- Write 0x10=A, then 0x10=B -> count stays 1. Read 0x10 -> up_dout=B next cycle, no mem_input_valid.
- With mem_ready=0, write DEPTH distinct lines -> full=1, up_ready=0. Release mem_ready -> drains in write order, up_ready returns after the first drain.
- Read miss 0x20 with memory returning C after 5 cycles -> exactly one read pulse with addr 0x20, then up_dout=C and up_out_valid one cycle after mem_out_valid. No drain issued during the miss.
- Issue 2*DEPTH+1 write/drain cycles -> head and tail wrap, and data order is preserved.
- Assert reset while in RD_WAIT -> outputs return to reset values, and a later mem_out_valid produces no up_out_valid.
